// File: rtl/desc_merge_pkg.sv
// ---------------------------------------------------------------------------
// desc_merge_pkg
//   Shared definitions for the descriptor merge arbiter:
//     - field offsets/widths of the 46-bit TSN descriptor
//     - field offsets/widths of the 22-bit standard-Ethernet lookup result
//     - STD_PKT_TYPE and std_to_desc(), which re-packs a standard result
//       into the TSN descriptor format
// ---------------------------------------------------------------------------
package desc_merge_pkg;

    localparam int DESC_W = 46;
    localparam int STD_W  = 22;

    typedef logic [DESC_W-1:0] desc_t;
    typedef logic [STD_W-1:0]  std_t;

    // TSN descriptor layout
    localparam int DESC_ADDR_LSB    = 41;   // [45:41]
    localparam int DESC_ADDR_W      = 5;
    localparam int DESC_RSV_BIT     = 40;
    localparam int DESC_INPORT_LSB  = 36;   // [39:36]
    localparam int DESC_TYPE_LSB    = 33;   // [35:33]
    localparam int DESC_FLOWID_LSB  = 19;   // [32:19]
    localparam int DESC_FLOWID_W    = 14;
    localparam int DESC_LOOKUP_BIT  = 18;
    localparam int DESC_OUTPORT_LSB = 9;    // [17:9]
    localparam int DESC_BUFID_LSB   = 0;    // [8:0]

    // Standard lookup result layout
    localparam int STD_INPORT_LSB   = 18;   // [21:18]
    localparam int STD_OUTPORT_LSB  = 9;    // [17:9]
    localparam int STD_BUFID_LSB    = 0;    // [8:0]

    // Field widths common to both formats
    localparam int INPORT_W  = 4;
    localparam int TYPE_W    = 3;
    localparam int OUTPORT_W = 9;
    localparam int BUFID_W   = 9;

    localparam logic [TYPE_W-1:0] STD_PKT_TYPE = 3'b111;

    // Standard results carry no address, flow id or lookup flag; those
    // fields are zero and the type field marks the descriptor as standard.
    function automatic desc_t std_to_desc(input std_t std_res);
        desc_t d;
        d = '0;
        d[DESC_INPORT_LSB  +: INPORT_W]  = std_res[STD_INPORT_LSB  +: INPORT_W];
        d[DESC_TYPE_LSB    +: TYPE_W]    = STD_PKT_TYPE;
        d[DESC_OUTPORT_LSB +: OUTPORT_W] = std_res[STD_OUTPORT_LSB +: OUTPORT_W];
        d[DESC_BUFID_LSB   +: BUFID_W]   = std_res[STD_BUFID_LSB   +: BUFID_W];
        return d;
    endfunction

endpackage

// File: rtl/desc_sync_fifo.sv
// ---------------------------------------------------------------------------
// desc_sync_fifo
//   Small synchronous first-word-fall-through FIFO. ov_dout shows the head
//   entry whenever o_empty is low. A push into a full FIFO is accepted only
//   when a pop happens in the same cycle; otherwise it is ignored (the
//   parent counts it as a drop).
//
//   Ports
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     i_push          write request, iv_din written when accepted
//     i_pop           remove head entry (ignored when empty)
//     ov_dout         head entry, valid while !o_empty
//     o_empty/o_full  occupancy flags
// ---------------------------------------------------------------------------
module desc_sync_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4     // power of 2, >= 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] iv_din,
    output logic [WIDTH-1:0] ov_dout,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_OCC);
    assign w_pop   = i_pop && !o_empty;
    // The slot freed by a same-cycle pop may be reused immediately.
    assign w_push  = i_push && (!o_full || w_pop);

    assign ov_dout = r_mem[r_rd_ptr];

    // Storage carries no reset: entries are only meaningful below r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iv_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/descriptor_merge_arbiter.sv
// ---------------------------------------------------------------------------
// descriptor_merge_arbiter
//   Merges the TSN descriptor stream and the standard-Ethernet lookup result
//   stream into one TSN-format descriptor stream. Each source is buffered in
//   its own FIFO; a round-robin arbiter feeds a single registered output
//   with a valid/ready handshake. Writes arriving at a full FIFO are dropped
//   and counted in saturating counters.
//
//   Ports
//     i_clk, i_rst_n          clock, asynchronous active-low reset
//     iv_tsn_descriptor       46-bit TSN descriptor, i_tsn_descriptor_wr strobe
//     iv_std_result           22-bit standard result, i_std_result_wr strobe
//     ov_descriptor           merged descriptor (TSN format)
//     o_descriptor_wr         output valid
//     i_descriptor_ready      downstream ready
//     ov_tsn_drop_cnt         TSN writes dropped on a full FIFO
//     ov_std_drop_cnt         std writes dropped on a full FIFO
// ---------------------------------------------------------------------------
module descriptor_merge_arbiter
    import desc_merge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DESC_W-1:0] iv_tsn_descriptor,
    input  logic              i_tsn_descriptor_wr,
    input  logic [STD_W-1:0]  iv_std_result,
    input  logic              i_std_result_wr,
    output logic [DESC_W-1:0] ov_descriptor,
    output logic              o_descriptor_wr,
    input  logic              i_descriptor_ready,
    output logic [CNT_W-1:0]  ov_tsn_drop_cnt,
    output logic [CNT_W-1:0]  ov_std_drop_cnt
);

    logic [DESC_W-1:0] w_tsn_dout;
    logic              w_tsn_empty;
    logic              w_tsn_full;
    logic [STD_W-1:0]  w_std_dout;
    logic              w_std_empty;
    logic              w_std_full;
    logic [DESC_W-1:0] w_std_desc;

    logic w_load;
    logic w_grant_tsn;
    logic w_grant_std;
    logic w_tsn_drop;
    logic w_std_drop;

    logic [DESC_W-1:0] r_descriptor;
    logic              r_descriptor_wr;
    logic              r_last_std;      // 1: std was served most recently
    logic [CNT_W-1:0]  r_tsn_drop_cnt;
    logic [CNT_W-1:0]  r_std_drop_cnt;

    desc_sync_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tsn_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_tsn_descriptor_wr),
        .i_pop   (w_grant_tsn),
        .iv_din  (iv_tsn_descriptor),
        .ov_dout (w_tsn_dout),
        .o_empty (w_tsn_empty),
        .o_full  (w_tsn_full)
    );

    desc_sync_fifo #(
        .WIDTH (STD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_std_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_std_result_wr),
        .i_pop   (w_grant_std),
        .iv_din  (iv_std_result),
        .ov_dout (w_std_dout),
        .o_empty (w_std_empty),
        .o_full  (w_std_full)
    );

    // Re-pack at the FIFO output so only 22 bits per std entry are stored.
    assign w_std_desc = std_to_desc(w_std_dout);

    // The output register may refill whenever it is empty or being consumed.
    assign w_load = !r_descriptor_wr || i_descriptor_ready;

    // r_last_std tracks the source of every grant, so with both FIFOs
    // non-empty the source not served last wins. Reset value 1 gives TSN
    // the first turn.
    assign w_grant_tsn = w_load && !w_tsn_empty && (w_std_empty || r_last_std);
    assign w_grant_std = w_load && !w_std_empty && (w_tsn_empty || !r_last_std);

    // Same condition the FIFO uses to refuse a push.
    assign w_tsn_drop = i_tsn_descriptor_wr && w_tsn_full && !w_grant_tsn;
    assign w_std_drop = i_std_result_wr     && w_std_full && !w_grant_std;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_descriptor    <= '0;
            r_descriptor_wr <= 1'b0;
            r_last_std      <= 1'b1;
        end else if (w_grant_tsn) begin
            r_descriptor    <= w_tsn_dout;
            r_descriptor_wr <= 1'b1;
            r_last_std      <= 1'b0;
        end else if (w_grant_std) begin
            r_descriptor    <= w_std_desc;
            r_descriptor_wr <= 1'b1;
            r_last_std      <= 1'b1;
        end else if (w_load) begin
            // Nothing to send: drop valid, keep the last descriptor value.
            r_descriptor_wr <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tsn_drop_cnt <= '0;
            r_std_drop_cnt <= '0;
        end else begin
            if (w_tsn_drop && (r_tsn_drop_cnt != '1)) begin
                r_tsn_drop_cnt <= r_tsn_drop_cnt + CNT_W'(1);
            end
            if (w_std_drop && (r_std_drop_cnt != '1)) begin
                r_std_drop_cnt <= r_std_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign ov_descriptor   = r_descriptor;
    assign o_descriptor_wr = r_descriptor_wr;
    assign ov_tsn_drop_cnt = r_tsn_drop_cnt;
    assign ov_std_drop_cnt = r_std_drop_cnt;

endmodule

// File: tb/tb_descriptor_merge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_descriptor_merge_arbiter
//   Directed scenarios plus a randomized run against a queue-based model.
// ---------------------------------------------------------------------------
module tb_descriptor_merge_arbiter;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          i_clk;
    logic          i_rst_n;
    logic [45:0]   iv_tsn_descriptor;
    logic          i_tsn_descriptor_wr;
    logic [21:0]   iv_std_result;
    logic          i_std_result_wr;
    logic [45:0]   ov_descriptor;
    logic          o_descriptor_wr;
    logic          i_descriptor_ready;
    logic [CW-1:0] ov_tsn_drop_cnt;
    logic [CW-1:0] ov_std_drop_cnt;

    int checks   = 0;
    int failures = 0;

    logic [45:0] got_q[$];

    descriptor_merge_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .iv_tsn_descriptor   (iv_tsn_descriptor),
        .i_tsn_descriptor_wr (i_tsn_descriptor_wr),
        .iv_std_result       (iv_std_result),
        .i_std_result_wr     (i_std_result_wr),
        .ov_descriptor       (ov_descriptor),
        .o_descriptor_wr     (o_descriptor_wr),
        .i_descriptor_ready  (i_descriptor_ready),
        .ov_tsn_drop_cnt     (ov_tsn_drop_cnt),
        .ov_std_drop_cnt     (ov_std_drop_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #4 i_clk = ~i_clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Standard result -> TSN descriptor, straight from the field table.
    function automatic logic [45:0] pack_std(input logic [21:0] r);
        return {5'd0, 1'b0, r[21:18], 3'b111, 14'd0, 1'b0, r[17:9], r[8:0]};
    endfunction

    function automatic logic [45:0] rand46();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[45:0];
    endfunction

    function automatic logic [21:0] rand22();
        logic [31:0] t;
        t = $urandom();
        return t[21:0];
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n             = 1'b0;
        i_tsn_descriptor_wr = 1'b0;
        i_std_result_wr     = 1'b0;
        i_descriptor_ready  = 1'b0;
        iv_tsn_descriptor   = '0;
        iv_std_result       = '0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    // Records every handshake (valid && ready before an edge) until n
    // descriptors have been collected or the cycle budget runs out.
    task automatic drain(input int n, input int max_cycles);
        for (int c = 0; c < max_cycles && got_q.size() < n; c++) begin
            if (o_descriptor_wr && i_descriptor_ready) got_q.push_back(ov_descriptor);
            tick();
        end
    endtask

    task automatic test_reset();
        i_rst_n             = 1'b0;
        i_tsn_descriptor_wr = 1'b0;
        i_std_result_wr     = 1'b0;
        i_descriptor_ready  = 1'b0;
        iv_tsn_descriptor   = '0;
        iv_std_result       = '0;
        tick();
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b0) begin failures++; $display("FAIL reset_wr: got %b want 0", o_descriptor_wr); end
        checks++;
        if (ov_descriptor !== 46'd0) begin failures++; $display("FAIL reset_desc: got %h want 0", ov_descriptor); end
        checks++;
        if (ov_tsn_drop_cnt !== '0 || ov_std_drop_cnt !== '0) begin
            failures++; $display("FAIL reset_cnt: got tsn=%0d std=%0d want 0/0", ov_tsn_drop_cnt, ov_std_drop_cnt);
        end
        i_rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b0) begin failures++; $display("FAIL reset_idle_wr: got %b want 0", o_descriptor_wr); end
        $display("test_reset done");
    endtask

    task automatic test_single_tsn();
        logic [45:0] v;
        v = 46'h0_1234_5678_9A;
        do_reset();
        i_descriptor_ready  = 1'b1;
        iv_tsn_descriptor   = v;
        i_tsn_descriptor_wr = 1'b1;
        tick();
        i_tsn_descriptor_wr = 1'b0;
        checks++;
        if (o_descriptor_wr !== 1'b0) begin failures++; $display("FAIL tsn_lat_early: got wr=%b want 0 after 1 edge", o_descriptor_wr); end
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b1) begin failures++; $display("FAIL tsn_lat: got wr=%b want 1 after 2 edges", o_descriptor_wr); end
        checks++;
        if (ov_descriptor !== v) begin failures++; $display("FAIL tsn_value: got %h want %h", ov_descriptor, v); end
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b0) begin failures++; $display("FAIL tsn_one_cycle: got wr=%b want 0", o_descriptor_wr); end
        checks++;
        if (ov_descriptor !== v) begin failures++; $display("FAIL tsn_hold_last: got %h want %h", ov_descriptor, v); end
        $display("test_single_tsn desc=%h", v);
    endtask

    task automatic test_single_std();
        logic [21:0] r;
        logic [45:0] exp;
        r   = {4'h8, 9'h002, 9'h005};
        exp = {5'h0, 1'b0, 4'h8, 3'b111, 14'h0, 1'b0, 9'h002, 9'h005};
        do_reset();
        i_descriptor_ready = 1'b1;
        iv_std_result      = r;
        i_std_result_wr    = 1'b1;
        tick();
        i_std_result_wr = 1'b0;
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b1) begin failures++; $display("FAIL std_valid: got wr=%b want 1", o_descriptor_wr); end
        checks++;
        if (ov_descriptor !== exp) begin failures++; $display("FAIL std_repack: got %h want %h", ov_descriptor, exp); end
        $display("test_single_std in=%h out=%h", r, exp);
    endtask

    task automatic test_simultaneous();
        logic [45:0] tv [3];
        logic [21:0] sv [3];
        logic [45:0] exp [6];
        do_reset();
        i_descriptor_ready = 1'b1;
        got_q.delete();
        for (int k = 0; k < 3; k++) begin
            tv[k] = rand46();
            sv[k] = rand22();
            exp[2*k]   = tv[k];
            exp[2*k+1] = pack_std(sv[k]);
            iv_tsn_descriptor   = tv[k];
            iv_std_result       = sv[k];
            i_tsn_descriptor_wr = 1'b1;
            i_std_result_wr     = 1'b1;
            if (o_descriptor_wr && i_descriptor_ready) got_q.push_back(ov_descriptor);
            tick();
        end
        i_tsn_descriptor_wr = 1'b0;
        i_std_result_wr     = 1'b0;
        drain(6, 40);
        checks++;
        if (got_q.size() != 6) begin failures++; $display("FAIL simul_count: got %0d descriptors want 6", got_q.size()); end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp[k]) begin failures++; $display("FAIL simul_order[%0d]: got %h want %h", k, got_q[k], exp[k]); end
        end
        checks++;
        if (ov_tsn_drop_cnt !== '0 || ov_std_drop_cnt !== '0) begin
            failures++; $display("FAIL simul_drops: got tsn=%0d std=%0d want 0/0", ov_tsn_drop_cnt, ov_std_drop_cnt);
        end
        $display("test_simultaneous outputs=%0d", got_q.size());
    endtask

    task automatic test_backpressure();
        logic [45:0] w [6];
        do_reset();
        i_descriptor_ready = 1'b0;
        for (int k = 0; k < 6; k++) w[k] = rand46();
        for (int k = 0; k < 5; k++) begin
            iv_tsn_descriptor   = w[k];
            i_tsn_descriptor_wr = 1'b1;
            tick();
        end
        i_tsn_descriptor_wr = 1'b0;
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b1 || ov_descriptor !== w[0]) begin
            failures++; $display("FAIL bp_head: got wr=%b %h want 1 %h", o_descriptor_wr, ov_descriptor, w[0]);
        end
        checks++;
        if (ov_tsn_drop_cnt !== '0) begin failures++; $display("FAIL bp_nodrop: got %0d want 0", ov_tsn_drop_cnt); end
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b1 || ov_descriptor !== w[0]) begin
            failures++; $display("FAIL bp_hold: got wr=%b %h want 1 %h", o_descriptor_wr, ov_descriptor, w[0]);
        end
        iv_tsn_descriptor   = w[5];
        i_tsn_descriptor_wr = 1'b1;
        tick();
        i_tsn_descriptor_wr = 1'b0;
        checks++;
        if (ov_tsn_drop_cnt !== 16'd1) begin failures++; $display("FAIL bp_drop: got %0d want 1", ov_tsn_drop_cnt); end
        i_descriptor_ready = 1'b1;
        got_q.delete();
        drain(5, 40);
        checks++;
        if (got_q.size() != 5) begin failures++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== w[k]) begin failures++; $display("FAIL bp_order[%0d]: got %h want %h", k, got_q[k], w[k]); end
        end
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b0) begin failures++; $display("FAIL bp_empty: got wr=%b want 0", o_descriptor_wr); end
        $display("test_backpressure drained=%0d drops=%0d", got_q.size(), ov_tsn_drop_cnt);
    endtask

    task automatic test_full_pop_push();
        logic [45:0] w [6];
        do_reset();
        i_descriptor_ready = 1'b0;
        for (int k = 0; k < 6; k++) w[k] = rand46();
        for (int k = 0; k < 5; k++) begin
            iv_tsn_descriptor   = w[k];
            i_tsn_descriptor_wr = 1'b1;
            tick();
        end
        i_tsn_descriptor_wr = 1'b0;
        tick();
        // FIFO full (4) + output register occupied; pop and write together.
        got_q.delete();
        i_descriptor_ready  = 1'b1;
        iv_tsn_descriptor   = w[5];
        i_tsn_descriptor_wr = 1'b1;
        if (o_descriptor_wr && i_descriptor_ready) got_q.push_back(ov_descriptor);
        tick();
        i_tsn_descriptor_wr = 1'b0;
        checks++;
        if (ov_tsn_drop_cnt !== '0) begin failures++; $display("FAIL fullpop_nodrop: got %0d want 0", ov_tsn_drop_cnt); end
        drain(6, 40);
        checks++;
        if (got_q.size() != 6) begin failures++; $display("FAIL fullpop_count: got %0d want 6", got_q.size()); end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== w[k]) begin failures++; $display("FAIL fullpop_order[%0d]: got %h want %h", k, got_q[k], w[k]); end
        end
        $display("test_full_pop_push drained=%0d", got_q.size());
    endtask

    task automatic test_async_reset();
        int stale;
        do_reset();
        i_descriptor_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv_tsn_descriptor   = rand46() | 46'd1;
            i_tsn_descriptor_wr = 1'b1;
            tick();
        end
        i_tsn_descriptor_wr = 1'b0;
        tick();
        checks++;
        if (o_descriptor_wr !== 1'b1) begin failures++; $display("FAIL arst_pre: got wr=%b want 1", o_descriptor_wr); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_descriptor_wr !== 1'b0 || ov_descriptor !== 46'd0) begin
            failures++; $display("FAIL arst_immediate: got wr=%b %h want 0 0", o_descriptor_wr, ov_descriptor);
        end
        tick();
        tick();
        i_rst_n            = 1'b1;
        i_descriptor_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_descriptor_wr) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL arst_stale: got %0d valid cycles want 0", stale); end
        $display("test_async_reset stale=%0d", stale);
    endtask

    // Queue model: one queue per source, an output slot, the source served
    // last, and drop tallies. Updated once per clock from the inputs that
    // the DUT samples at that edge.
    task automatic test_random();
        logic [45:0] tq[$];
        logic [45:0] sq[$];
        logic        m_valid;
        logic [45:0] m_desc;
        logic        m_last_std;
        logic [CW-1:0] m_tdrop;
        logic [CW-1:0] m_sdrop;
        int          rp, wp, outputs;
        logic        load, take_t, take_s;

        do_reset();
        m_valid = 1'b0; m_desc = '0; m_last_std = 1'b1;
        m_tdrop = '0; m_sdrop = '0; outputs = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc / 500) % 2 == 0) begin rp = 90; wp = 40; end
            else begin rp = 25; wp = 60; end
            i_tsn_descriptor_wr = ($urandom_range(0, 99) < wp);
            i_std_result_wr     = ($urandom_range(0, 99) < wp);
            i_descriptor_ready  = ($urandom_range(0, 99) < rp);
            iv_tsn_descriptor   = rand46();
            iv_std_result       = rand22();

            if (m_valid && i_descriptor_ready) outputs++;
            load   = !m_valid || i_descriptor_ready;
            take_t = 1'b0;
            take_s = 1'b0;
            if (load) begin
                if (tq.size() > 0 && sq.size() > 0) begin
                    if (m_last_std) take_t = 1'b1; else take_s = 1'b1;
                end else if (tq.size() > 0) take_t = 1'b1;
                else if (sq.size() > 0) take_s = 1'b1;
            end
            if (take_t) begin
                m_desc = tq.pop_front(); m_valid = 1'b1; m_last_std = 1'b0;
            end else if (take_s) begin
                m_desc = sq.pop_front(); m_valid = 1'b1; m_last_std = 1'b1;
            end else if (load) begin
                m_valid = 1'b0;
            end
            if (i_tsn_descriptor_wr) begin
                if (tq.size() < DEPTH) tq.push_back(iv_tsn_descriptor);
                else if (m_tdrop != '1) m_tdrop++;
            end
            if (i_std_result_wr) begin
                if (sq.size() < DEPTH) sq.push_back(pack_std(iv_std_result));
                else if (m_sdrop != '1) m_sdrop++;
            end

            tick();

            checks++;
            if (o_descriptor_wr !== m_valid) begin
                failures++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, o_descriptor_wr, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (ov_descriptor !== m_desc) begin
                    failures++; $display("FAIL rand_desc cyc=%0d: got %h want %h", cyc, ov_descriptor, m_desc);
                end
            end
            checks++;
            if (ov_tsn_drop_cnt !== m_tdrop) begin
                failures++; $display("FAIL rand_tsn_drop cyc=%0d: got %0d want %0d", cyc, ov_tsn_drop_cnt, m_tdrop);
            end
            checks++;
            if (ov_std_drop_cnt !== m_sdrop) begin
                failures++; $display("FAIL rand_std_drop cyc=%0d: got %0d want %0d", cyc, ov_std_drop_cnt, m_sdrop);
            end
        end
        i_tsn_descriptor_wr = 1'b0;
        i_std_result_wr     = 1'b0;
        $display("test_random outputs=%0d tsn_drops=%0d std_drops=%0d", outputs, m_tdrop, m_sdrop);
    endtask

    initial begin
        i_rst_n             = 1'b0;
        i_tsn_descriptor_wr = 1'b0;
        i_std_result_wr     = 1'b0;
        i_descriptor_ready  = 1'b0;
        iv_tsn_descriptor   = '0;
        iv_std_result       = '0;

        test_reset();
        test_single_tsn();
        test_single_std();
        test_simultaneous();
        test_backpressure();
        test_full_pop_push();
        test_async_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
